// File: rtl/des_cbc_framer_if.sv
// Byte-stream, configuration and DES-core signals of the CBC framer.
// The master side drives plaintext/config/core result; the slave side is the framer.
interface des_cbc_framer_if;
  logic [63:0] key_in;
  logic        key_load;
  logic [63:0] iv_in;
  logic        iv_load;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_byte;
  logic        in_last;
  logic [63:0] core_message;
  logic [63:0] core_key;
  logic [63:0] core_result;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        out_last;
  logic        busy;

  modport master (
    output key_in, key_load, iv_in, iv_load,
    output in_valid, in_byte, in_last, core_result, out_ready,
    input  in_ready, core_message, core_key, out_valid, out_byte, out_last, busy
  );

  modport slave (
    input  key_in, key_load, iv_in, iv_load,
    input  in_valid, in_byte, in_last, core_result, out_ready,
    output in_ready, core_message, core_key, out_valid, out_byte, out_last, busy
  );
endinterface

// File: rtl/des_cbc_framer.sv
// Packs plaintext bytes into 64-bit blocks, chains them through an external
// combinational DES core and streams the ciphertext back out byte by byte.
//
// state   | meaning
// COLLECT | accepting plaintext bytes into blk; key/iv loads allowed at cnt == 0
// SETTLE  | core inputs held stable while core_result settles
// EMIT    | ciphertext shifted out of obuf, MSB byte first
module des_cbc_framer #(
  parameter bit CBC_EN        = 1'b1,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  des_cbc_framer_if.slave bus
);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {COLLECT, SETTLE, EMIT} state_t;

  state_t          state, state_nxt;
  logic [63:0]     blk, key_r, iv_r, chain, obuf;
  logic [3:0]      cnt;
  logic [2:0]      ocnt;
  logic            final_f;
  logic [SW-1:0]   scnt;

  logic in_acc, out_acc, cfg_ok, blk_done, settle_done, emit_done;

  assign in_acc      = bus.in_valid & bus.in_ready;
  assign out_acc     = bus.out_valid & bus.out_ready;
  assign cfg_ok      = (state == COLLECT) && (cnt == 4'd0);
  assign blk_done    = in_acc && ((cnt[2:0] == 3'd7) || bus.in_last);
  assign settle_done = (state == SETTLE) && (scnt == SETTLE_LAST);
  assign emit_done   = out_acc && (ocnt == 3'd7);

  // ECB mode simply masks the chain; the register still tracks results.
  assign bus.core_message = blk ^ (CBC_EN ? chain : 64'h0);
  assign bus.core_key     = key_r;
  assign bus.out_byte     = obuf[63:56];
  assign bus.busy         = (state != COLLECT) || (cnt != 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    case (state)
      COLLECT: begin
        bus.in_ready = 1'b1;
        if (blk_done) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (settle_done) state_nxt = EMIT;
      end
      EMIT: begin
        bus.out_valid = 1'b1;
        bus.out_last  = final_f && (ocnt == 3'd7);
        if (emit_done) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk     <= '0;
      key_r   <= '0;
      iv_r    <= '0;
      chain   <= '0;
      obuf    <= '0;
      cnt     <= '0;
      ocnt    <= '0;
      final_f <= 1'b0;
      scnt    <= '0;
    end else begin
      if (cfg_ok && bus.key_load) key_r <= bus.key_in;
      if (cfg_ok && bus.iv_load) begin
        iv_r  <= bus.iv_in;
        chain <= bus.iv_in;
      end
      if (in_acc) begin
        blk[{~cnt[2:0], 3'b000} +: 8] <= bus.in_byte;
        cnt <= cnt + 4'd1;
        if (blk_done) begin
          final_f <= bus.in_last;
          scnt    <= '0;
        end
      end
      if (state == SETTLE) begin
        scnt <= scnt + 1'b1;
        if (settle_done) begin
          obuf  <= bus.core_result;
          chain <= bus.core_result;
          cnt   <= '0;
          blk   <= '0;
        end
      end
      if (out_acc) begin
        obuf <= {obuf[55:0], 8'h00};
        ocnt <= ocnt + 3'd1;
        // A finished message restarts the next one from the IV.
        if (emit_done && final_f) chain <= iv_r;
      end
    end
  end
endmodule

// File: tb/tb_des_cbc_framer.sv
// Scoreboard bench for des_cbc_framer: a CBC and an ECB instance share stimulus,
// each fed by a behavioural DES core; expected bytes come from a bench-side model.
module tb_des_cbc_framer;
  localparam int SETTLE = 2;
  localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] KAT_PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] KAT_CT  = 64'h85E813540F0AB405;

  localparam int IP_T[64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,
                              62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                              57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
                              61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
  localparam int FP_T[64] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,
                              38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,
                              36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,
                              34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
  localparam int E_T[48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                             16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  localparam int P_T[32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                             2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  localparam int PC1_T[56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                               63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  localparam int PC2_T[48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                               41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  localparam int SHIFTS[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int SBOX[512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  function automatic logic [63:0] des_enc(input logic [63:0] pt, input logic [63:0] key);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] sk [16];
    logic [63:0] x, pre, ct;
    logic [31:0] l, r, f, sout, nr;
    logic [47:0] e;
    logic [5:0]  six;
    int idx;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int n = 0; n < 16; n++) begin
      for (int s = 0; s < SHIFTS[n]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) sk[n][47-i] = cd[56-PC2_T[i]];
    end
    for (int i = 0; i < 64; i++) x[63-i] = pt[64-IP_T[i]];
    l = x[63:32];
    r = x[31:0];
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
      e = e ^ sk[n];
      for (int s = 0; s < 8; s++) begin
        six = e[47-6*s -: 6];
        idx = s*64 + int'({six[5], six[0]})*16 + int'(six[4:1]);
        sout[31-4*s -: 4] = 4'(SBOX[idx]);
      end
      for (int i = 0; i < 32; i++) f[31-i] = sout[32-P_T[i]];
      nr = l ^ f;
      l = r;
      r = nr;
    end
    pre = {r, l};
    for (int i = 0; i < 64; i++) ct[63-i] = pre[64-FP_T[i]];
    return ct;
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0, n_fail = 0, cyc = 0, acc_cyc = 0;

  des_cbc_framer_if bus();
  des_cbc_framer_if ebus();

  des_cbc_framer #(.CBC_EN(1'b1), .SETTLE_CYCLES(SETTLE)) dut (.clk(clk), .rst(rst), .bus(bus));
  des_cbc_framer #(.CBC_EN(1'b0), .SETTLE_CYCLES(SETTLE)) dut_ecb (.clk(clk), .rst(rst), .bus(ebus));

  assign ebus.key_in    = bus.key_in;
  assign ebus.key_load  = bus.key_load;
  assign ebus.iv_in     = bus.iv_in;
  assign ebus.iv_load   = bus.iv_load;
  assign ebus.in_valid  = bus.in_valid;
  assign ebus.in_byte   = bus.in_byte;
  assign ebus.in_last   = bus.in_last;
  assign ebus.out_ready = bus.out_ready;
  assign bus.core_result  = des_enc(bus.core_message, bus.core_key);
  assign ebus.core_result = des_enc(ebus.core_message, ebus.core_key);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard queues hold {last, byte}.
  logic [8:0] exp_q[$], rx_q[$], exp_e_q[$], rx_e_q[$];
  logic [7:0] tx_q[$];
  logic [63:0] m_key = '0, m_iv = '0, m_chain = '0, m_blk = '0;
  int m_cnt = 0;

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) rx_q.push_back({bus.out_last, bus.out_byte});
    if (!rst && ebus.out_valid && ebus.out_ready) rx_e_q.push_back({ebus.out_last, ebus.out_byte});
  end

  task automatic send_msg(input bit last_flag);
    int n;
    int t;
    logic lst;
    logic lb;
    logic [63:0] ct, ect;
    n = tx_q.size();
    for (int i = 0; i < n; i++) begin
      lst = last_flag && (i == n - 1);
      bus.in_valid = 1'b1;
      bus.in_byte  = tx_q[i];
      bus.in_last  = lst;
      t = 0;
      @(negedge clk);
      while (!bus.in_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) begin
        n_chk++;
        n_fail++;
        $display("FAIL in_accept_timeout: in_ready=%b required 1", bus.in_ready);
      end
      acc_cyc = cyc;
      @(posedge clk);
      #1;
      m_blk[8*(7-m_cnt) +: 8] = tx_q[i];
      m_cnt++;
      if (m_cnt == 8 || lst) begin
        ct  = des_enc(m_blk ^ m_chain, m_key);
        ect = des_enc(m_blk, m_key);
        for (int b = 0; b < 8; b++) begin
          lb = lst && (b == 7);
          exp_q.push_back({lb, ct[63-8*b -: 8]});
          exp_e_q.push_back({lb, ect[63-8*b -: 8]});
        end
        m_chain = lst ? m_iv : ct;
        m_blk   = '0;
        m_cnt   = 0;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    tx_q.delete();
  endtask

  task automatic load_cfg(input logic [63:0] k, input logic [63:0] v, input bit dk, input bit dv);
    @(posedge clk);
    #1;
    bus.key_in   = k;
    bus.iv_in    = v;
    bus.key_load = dk;
    bus.iv_load  = dv;
    @(posedge clk);
    #1;
    bus.key_load = 1'b0;
    bus.iv_load  = 1'b0;
    if (dk) m_key = k;
    if (dv) begin
      m_iv    = v;
      m_chain = v;
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((rx_q.size() < exp_q.size() || rx_e_q.size() < exp_e_q.size()) && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (t >= 500) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d bytes, required %0d", rx_q.size(), exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk += 6;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b required 0", bus.out_valid); end
    if (bus.out_byte !== 8'h00) begin n_fail++; $display("FAIL rst_out_byte: got %h required 00", bus.out_byte); end
    if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL rst_out_last: got %b required 0", bus.out_last); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", bus.busy); end
    if (bus.core_key !== 64'h0) begin n_fail++; $display("FAIL rst_core_key: got %h required 0", bus.core_key); end
    if (bus.core_message !== 64'h0) begin n_fail++; $display("FAIL rst_core_message: got %h required 0", bus.core_message); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_chk++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b required 1", bus.in_ready); end
  endtask

  task automatic test_ecb_kat();
    logic [8:0] e, g;
    int t = 0;
    load_cfg(KAT_KEY, 64'h0, 1'b1, 1'b1);
    tx_q = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    send_msg(1'b1);
    @(negedge clk);
    while (!bus.out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if (cyc - acc_cyc != SETTLE + 1)
      begin n_fail++; $display("FAIL kat_latency: got %0d cycles required %0d", cyc - acc_cyc, SETTLE + 1); end
    wait_drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = 'x;
      if (rx_q.size() > 0) g = rx_q.pop_front();
      n_chk++;
      if (g !== e) begin n_fail++; $display("FAIL kat_cbc byte: got %h required %h", g, e); end
    end
    exp_e_q.delete();
    for (int b = 0; b < 8; b++) begin
      e = {(b == 7), KAT_CT[63-8*b -: 8]};
      g = 'x;
      if (rx_e_q.size() > 0) g = rx_e_q.pop_front();
      n_chk++;
      if (g !== e) begin n_fail++; $display("FAIL kat_ecb byte%0d: got %h required %h", b, g, e); end
    end
  endtask

  task automatic test_cbc_two();
    logic [8:0] e, g;
    load_cfg(KAT_KEY, 64'h0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) tx_q.push_back(KAT_PT[63-8*(i%8) -: 8]);
    send_msg(1'b1);
    @(negedge clk);
    n_chk++;
    if (bus.core_message !== (KAT_PT ^ KAT_CT))
      begin n_fail++; $display("FAIL cbc_block2_msg: got %h required %h", bus.core_message, KAT_PT ^ KAT_CT); end
    wait_drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = 'x;
      if (rx_q.size() > 0) g = rx_q.pop_front();
      n_chk++;
      if (g !== e) begin n_fail++; $display("FAIL cbc_two byte: got %h required %h", g, e); end
    end
    n_chk++;
    if (rx_q.size() != 0) begin n_fail++; $display("FAIL cbc_two extra: got %0d extra bytes required 0", rx_q.size()); end
    exp_e_q.delete();
    rx_e_q.delete();
  endtask

  task automatic test_short();
    logic [8:0] e, g;
    load_cfg(64'h0, 64'h0F1E2D3C4B5A6978, 1'b0, 1'b1);
    tx_q = '{8'hAA, 8'hBB, 8'hCC};
    send_msg(1'b1);
    @(negedge clk);
    n_chk += 3;
    if (bus.core_message !== (64'hAABBCC0000000000 ^ 64'h0F1E2D3C4B5A6978))
      begin n_fail++; $display("FAIL short_msg: got %h required %h", bus.core_message, 64'hAABBCC0000000000 ^ 64'h0F1E2D3C4B5A6978); end
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL short_busy: got %b required 1", bus.busy); end
    if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL short_in_ready: got %b required 0", bus.in_ready); end
    wait_drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = 'x;
      if (rx_q.size() > 0) g = rx_q.pop_front();
      n_chk++;
      if (g !== e) begin n_fail++; $display("FAIL short byte: got %h required %h", g, e); end
    end
    n_chk++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL short_idle_busy: got %b required 0", bus.busy); end
    exp_e_q.delete();
    rx_e_q.delete();
  endtask

  task automatic test_backpressure();
    logic [8:0] e, g;
    logic [7:0] hold;
    int t = 0;
    tx_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    send_msg(1'b1);
    while (rx_q.size() < 3 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    bus.out_ready = 1'b0;
    hold = exp_q[3][7:0];
    repeat (5) begin
      @(negedge clk);
      n_chk += 3;
      if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b required 1", bus.out_valid); end
      if (bus.out_byte !== hold) begin n_fail++; $display("FAIL bp_byte: got %h required %h", bus.out_byte, hold); end
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b required 0", bus.in_ready); end
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = 'x;
      if (rx_q.size() > 0) g = rx_q.pop_front();
      n_chk++;
      if (g !== e) begin n_fail++; $display("FAIL bp byte: got %h required %h", g, e); end
    end
    n_chk++;
    if (rx_q.size() != 0) begin n_fail++; $display("FAIL bp_extra: got %0d extra bytes required 0", rx_q.size()); end
    exp_e_q.delete();
    rx_e_q.delete();
  endtask

  task automatic test_ignored_loads();
    logic [8:0] e, g;
    tx_q = '{8'h21, 8'h22, 8'h23};
    send_msg(1'b0);
    bus.key_in   = 64'hFEDCBA9876543210;
    bus.iv_in    = 64'hFFFFFFFFFFFFFFFF;
    bus.key_load = 1'b1;
    bus.iv_load  = 1'b1;
    @(posedge clk);
    #1;
    bus.key_load = 1'b0;
    bus.iv_load  = 1'b0;
    tx_q = '{8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
    send_msg(1'b1);
    bus.key_load = 1'b1;
    @(posedge clk);
    #1;
    bus.key_load = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.core_key !== KAT_KEY) begin n_fail++; $display("FAIL ign_core_key: got %h required %h", bus.core_key, KAT_KEY); end
    wait_drain();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = 'x;
      if (rx_q.size() > 0) g = rx_q.pop_front();
      n_chk++;
      if (g !== e) begin n_fail++; $display("FAIL ign byte: got %h required %h", g, e); end
    end
    exp_e_q.delete();
    rx_e_q.delete();
  endtask

  task automatic test_reset_mid_emit();
    logic [8:0] e, g;
    int t = 0;
    tx_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
    send_msg(1'b1);
    while (rx_q.size() < 4 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    rst = 1'b1;
    #1;
    n_chk += 2;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rme_out_valid: got %b required 0", bus.out_valid); end
    if (ebus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rme_ecb_out_valid: got %b required 0", ebus.out_valid); end
    exp_q.delete();
    rx_q.delete();
    exp_e_q.delete();
    rx_e_q.delete();
    m_key = '0; m_iv = '0; m_chain = '0; m_blk = '0; m_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_chk += 3;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rme_in_ready: got %b required 1", bus.in_ready); end
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rme_busy: got %b required 0", bus.busy); end
    if (bus.core_message !== 64'h0) begin n_fail++; $display("FAIL rme_core_message: got %h required 0", bus.core_message); end
    load_cfg(KAT_KEY, 64'h0, 1'b1, 1'b0);
    tx_q = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    send_msg(1'b1);
    wait_drain();
    for (int b = 0; b < 8; b++) begin
      e = {(b == 7), KAT_CT[63-8*b -: 8]};
      g = 'x;
      if (rx_q.size() > 0) g = rx_q.pop_front();
      n_chk++;
      if (g !== e) begin n_fail++; $display("FAIL rme_cbc byte%0d: got %h required %h", b, g, e); end
      g = 'x;
      if (rx_e_q.size() > 0) g = rx_e_q.pop_front();
      n_chk++;
      if (g !== e) begin n_fail++; $display("FAIL rme_ecb byte%0d: got %h required %h", b, g, e); end
    end
    exp_q.delete();
    exp_e_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.key_in    = '0;
    bus.key_load  = 1'b0;
    bus.iv_in     = '0;
    bus.iv_load   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_byte   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_ecb_kat();
    test_cbc_two();
    test_short();
    test_backpressure();
    test_ignored_loads();
    test_reset_mid_emit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/des_cbc_framer.md
Name: des_cbc_framer

Overview:
- Byte-stream front/back end for the combinational 64-bit DES encryption core.
- Collects plaintext bytes into a 64-bit block and zero-pads a short final block.
- Applies CBC chaining (XOR with IV or previous ciphertext) and drives the core's message and key inputs.
- Waits a fixed settle time, captures the 64-bit core result, then serialises the ciphertext as bytes with a valid/ready handshake.

Parameters:
- CBC_EN, 1, 1 = CBC chaining; 0 = ECB, chain value forced to 0.
- SETTLE_CYCLES, 2, clock cycles between presenting core inputs and capturing core_result (min 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset.
- key_in  in  64  DES key, parity bits included.
- key_load  in  1  capture key_in.
- iv_in  in  64  CBC initial vector.
- iv_load  in  1  capture iv_in and reset the chain value to it.
- in_valid  in  1  in_byte valid.
- in_ready  out  1  framer accepts a byte.
- in_byte  in  8  plaintext byte, first byte lands in bits 63:56.
- in_last  in  1  marks the final byte of the message.
- core_message  out  64  plaintext block to the DES core.
- core_key  out  64  key to the DES core.
- core_result  in  64  ciphertext from the DES core.
- out_valid  out  1  out_byte valid.
- out_ready  in  1  downstream accepts a byte.
- out_byte  out  8  ciphertext byte, MSB byte first.
- out_last  out  1  final ciphertext byte of the message.
- busy  out  1  high in SETTLE/EMIT, or when byte count is non-zero.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset state:
  - All registers are 0 and state is COLLECT.
  - out_valid, out_byte, out_last, busy and core_key are 0; core_message is 0.
  - in_ready is 1 from the first clock after rst drops.
  - Asserting rst mid-block discards any partial input or output immediately.
- Registers:
  - blk: 64-bit block buffer.
  - cnt: 3-bit byte index plus a full flag.
  - key_r, iv_r, chain: 64 bits each.
  - obuf: 64-bit output shift register.
  - final_f: last-block flag.
  - scnt: settle counter.
- Combinational core outputs:
  - core_message = blk ^ (CBC_EN ? chain : 64'h0).
  - core_key = key_r.
- State COLLECT:
  - in_ready = 1.
  - On in_valid & in_ready, in_byte is written to blk[63-8*cnt -: 8] and cnt increments.
  - When the 8th byte is accepted, or any byte with in_last=1 is accepted, the unwritten bytes stay 0 (blk was cleared at block start). final_f <= in_last, scnt <= 0, and the state goes to SETTLE.
- State SETTLE:
  - in_ready = 0; blk, chain and key_r are held stable.
  - scnt increments each cycle.
  - On the cycle with scnt == SETTLE_CYCLES-1: obuf <= core_result, chain <= core_result, cnt <= 0, blk <= 0, state goes to EMIT.
- State EMIT:
  - out_valid = 1; out_byte = obuf[63:56].
  - out_last = final_f when 7 bytes have already been sent.
  - On out_valid & out_ready, obuf shifts left 8 and the sent count increments.
  - out_byte and out_valid hold while out_ready is low.
  - After the 8th transfer the state returns to COLLECT. If final_f, chain <= iv_r so the next message restarts from the IV.
- key_load / iv_load:
  - Honoured only in COLLECT with cnt == 0; ignored in every other state or count.
  - If key_load coincides with the first byte's acceptance, the new key applies to that block.
  - iv_load sets both iv_r and chain.
  - If iv_load coincides with the chain reload on a final block's last transfer, iv_load is ignored (not COLLECT).
- Latency: the last input byte accepted at cycle t gives first out_valid at t+SETTLE_CYCLES+1.
- An empty message is not representable: every accepted byte carries data.

Test Plan:
- ECB known answer. CBC_EN=0, key 133457799BBCDFF1, bytes 01 23 45 67 89 AB CD EF with in_last on byte 8 -> out bytes 85 E8 13 54 0F 0A B4 05, out_last only on 05.
- CBC two blocks. iv=0, same key, 16 bytes of 0123456789ABCDEF repeated -> block1 = 85E813540F0AB405; core_message for block2 = 0123456789ABCDEF ^ 85E813540F0AB405; output matches the software model.
- Short final block. 3 bytes AA BB CC with in_last -> core_message = AABBCC0000000000 ^ chain; 8 output bytes emitted, out_last on the 8th.
- Backpressure. out_ready low for 5 cycles mid-EMIT -> out_byte stable, no byte lost or duplicated; in_ready stays 0 until all 8 bytes are sent.
- Ignored loads. key_load pulsed during SETTLE and at cnt=3 -> key_r unchanged, ciphertext matches the old key.
- Reset mid-EMIT. rst asserted after 4 output bytes -> out_valid drops to 0 asynchronously; after release, in_ready=1, chain=0, and a new ECB block gives the known answer.
